// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction queue entry, queue FSM states and
// the default instruction queue depth.
package cpu_pkg;

  localparam int CPU_DATA_W      = 32;
  localparam int INST_FIFO_DEPTH = 16;

  // One queued instruction with the PC it was fetched from.
  typedef struct packed {
    logic [CPU_DATA_W-1:0] inst;
    logic [CPU_DATA_W-1:0] pc;
  } fifo_entry_t;

  // NORMAL: regular queueing. WAIT_DS: a branch issued without its delay
  // slot and the queue was empty, so the next fetched instruction is the
  // delay slot and is the only one that may be kept.
  typedef enum logic {
    NORMAL  = 1'b0,
    WAIT_DS = 1'b1
  } fifo_state_t;

endpackage : cpu_pkg

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and decode.
// Fetch pushes up to two {inst, pc} entries per cycle, decode pops up to two.
// Handles the branch flush including retention of an unissued delay slot.
// Optional build macro INST_FIFO_PERF_EN adds saturating performance counters
// (empty cycles, full cycles, flush cycles).
module inst_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH  = INST_FIFO_DEPTH,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_rst,
  input  logic              keep_ds,
  input  logic              delay_slot_flush,
  input  logic              w_en1,
  input  logic              w_en2,
  input  logic [DATA_W-1:0] w_inst1,
  input  logic [DATA_W-1:0] w_inst2,
  input  logic [DATA_W-1:0] w_pc1,
  input  logic [DATA_W-1:0] w_pc2,
  input  logic              r_en1,
  input  logic              r_en2,
  output logic [DATA_W-1:0] r_inst1,
  output logic [DATA_W-1:0] r_inst2,
  output logic [DATA_W-1:0] r_pc1,
  output logic [DATA_W-1:0] r_pc2,
  output logic              empty,
  output logic              almost_empty,
  output logic              full
`ifdef INST_FIFO_PERF_EN
  ,
  output logic [31:0]       perf_empty_cycles,
  output logic [31:0]       perf_full_cycles,
  output logic [31:0]       perf_flushes
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_ZERO = '0;
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_TWO  = cnt_t'(2);
  // Highest occupancy at which fetch may still push a full pair.
  localparam cnt_t CNT_ROOM = cnt_t'(DEPTH - 2);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  // Storage (data path, not reset: invalid entries are masked at the outputs)
  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [DATA_W-1:0] mem_pc   [DEPTH];

  // Control state
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  cnt_t        count_q,  count_d;
  fifo_state_t state_q,  state_d;

  // Per-cycle decode of the request
  cnt_t pop_req;
  cnt_t pops;
  cnt_t after_pop;
  cnt_t pushes;
  logic has_room;
  logic wr1_en;
  logic wr2_en;
  ptr_t wr_addr2;
  ptr_t rd_addr2;

  assign wr_addr2 = wr_ptr_q + PTR_ONE;
  assign rd_addr2 = rd_ptr_q + PTR_ONE;

  // Pop request clamped to occupancy; slot 2 only counts together with slot 1.
  // Room for pushes is judged after this cycle's pops, so a full queue that
  // is drained by two still accepts a pair in the same cycle.
  always_comb begin
    pop_req   = cnt_t'(r_en1) + cnt_t'(r_en1 & r_en2);
    pops      = (pop_req > count_q) ? count_q : pop_req;
    after_pop = count_q - pops;
    has_room  = (after_pop <= CNT_ROOM);
  end

  // Next-state for pointers, occupancy and FSM, including flush priority.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    wr1_en   = 1'b0;
    wr2_en   = 1'b0;
    pushes   = CNT_ZERO;

    if (delay_slot_flush || fifo_rst) begin
      // Exception or full pipeline flush: drop everything, same-cycle
      // pushes and pops included.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = CNT_ZERO;
      state_d  = NORMAL;
    end else if (keep_ds) begin
      if (count_q != CNT_ZERO) begin
        // The head is the delay slot of the issued branch: keep it only.
        wr_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = CNT_ONE;
      end else begin
        // Delay slot not fetched yet; the next fetched instruction is it.
        count_d  = CNT_ZERO;
        state_d  = WAIT_DS;
      end
    end else begin
      unique case (state_q)
        NORMAL: begin
          wr1_en   = w_en1 & has_room;
          wr2_en   = w_en1 & w_en2 & has_room;
          pushes   = cnt_t'(wr1_en) + cnt_t'(wr2_en);
          rd_ptr_d = rd_ptr_q + ptr_t'(pops);
          wr_ptr_d = wr_ptr_q + ptr_t'(pushes);
          count_d  = after_pop + pushes;
        end
        WAIT_DS: begin
          // Queue is empty here, so pops have nothing to act on. Only the
          // delay slot (slot 1) is kept; slot 2 is on the wrong path.
          if (w_en1) begin
            wr1_en   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
            state_d  = NORMAL;
          end
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= CNT_ZERO;
      state_q  <= NORMAL;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Entry storage write; slot 2 lands right after slot 1.
  always_ff @(posedge clk) begin
    if (wr1_en) begin
      mem_inst[wr_ptr_q] <= w_inst1;
      mem_pc[wr_ptr_q]   <= w_pc1;
    end
    if (wr2_en) begin
      mem_inst[wr_addr2] <= w_inst2;
      mem_pc[wr_addr2]   <= w_pc2;
    end
  end

  // Combinational head/head+1 reads, zeroed when the entry is not valid.
  always_comb begin
    r_inst1 = '0;
    r_pc1   = '0;
    r_inst2 = '0;
    r_pc2   = '0;
    if (count_q >= CNT_ONE) begin
      r_inst1 = mem_inst[rd_ptr_q];
      r_pc1   = mem_pc[rd_ptr_q];
    end
    if (count_q >= CNT_TWO) begin
      r_inst2 = mem_inst[rd_addr2];
      r_pc2   = mem_pc[rd_addr2];
    end
  end

  assign empty        = (count_q == CNT_ZERO);
  assign almost_empty = (count_q == CNT_ONE);
  assign full         = (count_q > CNT_ROOM);

`ifdef INST_FIFO_PERF_EN
  logic [31:0] perf_empty_q, perf_empty_d;
  logic [31:0] perf_full_q,  perf_full_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Saturating event counts for the current cycle.
  always_comb begin
    perf_empty_d = sat_inc(perf_empty_q, empty && (state_q == NORMAL));
    perf_full_d  = sat_inc(perf_full_q, full);
    perf_flush_d = sat_inc(perf_flush_q, fifo_rst | keep_ds | delay_slot_flush);
  end

  // Performance counters, cleared only by the global reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_empty_q <= '0;
      perf_full_q  <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_empty_q <= perf_empty_d;
      perf_full_q  <= perf_full_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_empty_cycles = perf_empty_q;
  assign perf_full_cycles  = perf_full_q;
  assign perf_flushes      = perf_flush_q;
`endif

`ifndef SYNTHESIS
  // Slot 2 requests are only meaningful together with slot 1.
  a_w_en2_needs_w_en1 : assert property (@(posedge clk) disable iff (rst) w_en2 |-> w_en1);
  a_r_en2_needs_r_en1 : assert property (@(posedge clk) disable iff (rst) r_en2 |-> r_en1);
`endif

endmodule : inst_fifo

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: directed scenarios followed by random
// legal traffic, all compared against a queue-based reference model.
module tb_inst_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_rst = 1'b0, keep_ds = 1'b0, delay_slot_flush = 1'b0;
  logic              w_en1 = 1'b0, w_en2 = 1'b0, r_en1 = 1'b0, r_en2 = 1'b0;
  logic [DATA_W-1:0] w_inst1 = '0, w_inst2 = '0, w_pc1 = '0, w_pc2 = '0;
  logic [DATA_W-1:0] r_inst1, r_inst2, r_pc1, r_pc2;
  logic              empty, almost_empty, full;
`ifdef INST_FIFO_PERF_EN
  logic [31:0]       perf_empty_cycles, perf_full_cycles, perf_flushes;
`endif

  inst_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .fifo_rst(fifo_rst), .keep_ds(keep_ds),
    .delay_slot_flush(delay_slot_flush),
    .w_en1(w_en1), .w_en2(w_en2),
    .w_inst1(w_inst1), .w_inst2(w_inst2), .w_pc1(w_pc1), .w_pc2(w_pc2),
    .r_en1(r_en1), .r_en2(r_en2),
    .r_inst1(r_inst1), .r_inst2(r_inst2), .r_pc1(r_pc1), .r_pc2(r_pc2),
    .empty(empty), .almost_empty(almost_empty), .full(full)
`ifdef INST_FIFO_PERF_EN
    , .perf_empty_cycles(perf_empty_cycles), .perf_full_cycles(perf_full_cycles),
    .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ordered list of {inst, pc}, plus "waiting for delay slot".
  logic [63:0] mq[$];
  bit          m_wait_ds = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Apply the current inputs to the model as one clock cycle.
  task automatic model_update();
    int npop;
    bit room;
    logic [63:0] head;
    if (delay_slot_flush || fifo_rst) begin
      mq.delete();
      m_wait_ds = 1'b0;
    end else if (keep_ds) begin
      if (mq.size() > 0) begin
        head = mq[0];
        mq.delete();
        mq.push_back(head);
      end else begin
        m_wait_ds = 1'b1;
      end
    end else if (m_wait_ds) begin
      if (w_en1) begin
        mq.push_back({w_inst1, w_pc1});
        m_wait_ds = 1'b0;
      end
    end else begin
      npop = r_en1 ? (r_en2 ? 2 : 1) : 0;
      if (npop > mq.size()) npop = mq.size();
      for (int i = 0; i < npop; i++) void'(mq.pop_front());
      room = (mq.size() <= DEPTH - 2);
      if (room && w_en1) mq.push_back({w_inst1, w_pc1});
      if (room && w_en1 && w_en2) mq.push_back({w_inst2, w_pc2});
    end
  endtask

  task automatic compare_all(input string tag);
    logic [63:0] e1, e2;
    e1 = (mq.size() >= 1) ? mq[0] : 64'd0;
    e2 = (mq.size() >= 2) ? mq[1] : 64'd0;
    check_eq({tag, ".inst1"}, {32'd0, r_inst1}, {32'd0, e1[63:32]});
    check_eq({tag, ".pc1"},   {32'd0, r_pc1},   {32'd0, e1[31:0]});
    check_eq({tag, ".inst2"}, {32'd0, r_inst2}, {32'd0, e2[63:32]});
    check_eq({tag, ".pc2"},   {32'd0, r_pc2},   {32'd0, e2[31:0]});
    check_eq({tag, ".empty"}, {63'd0, empty}, {63'd0, mq.size() == 0});
    check_eq({tag, ".aempty"}, {63'd0, almost_empty}, {63'd0, mq.size() == 1});
    check_eq({tag, ".full"}, {63'd0, full}, {63'd0, mq.size() > DEPTH - 2});
  endtask

  task automatic idle_inputs();
    fifo_rst = 0; keep_ds = 0; delay_slot_flush = 0;
    w_en1 = 0; w_en2 = 0; r_en1 = 0; r_en2 = 0;
  endtask

  // One clock with the inputs currently driven, then check and go idle.
  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    compare_all(tag);
    idle_inputs();
  endtask

  task automatic push1(input logic [31:0] i, input logic [31:0] p);
    w_en1 = 1; w_inst1 = i; w_pc1 = p;
  endtask

  task automatic push2(input logic [31:0] i1, input logic [31:0] p1,
                       input logic [31:0] i2, input logic [31:0] p2);
    w_en1 = 1; w_en2 = 1; w_inst1 = i1; w_pc1 = p1; w_inst2 = i2; w_pc2 = p2;
  endtask

  logic [31:0] saved_pc;

  initial begin
    // Reset, then idle
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    check_eq("rst.empty", {63'd0, empty}, 64'd1);
    check_eq("rst.inst1", {32'd0, r_inst1}, 64'd0);
    step("idle");

    // First pair becomes visible the next cycle
    push2(32'h1, 32'hBFC0_0000, 32'h2, 32'hBFC0_0004);
    step("pair");
    check_eq("pair.pc1", {32'd0, r_pc1}, 64'hBFC0_0000);
    check_eq("pair.pc2", {32'd0, r_pc2}, 64'hBFC0_0004);
    check_eq("pair.empty", {63'd0, empty}, 64'd0);

    // Fill to 15 with single pushes
    for (int k = 0; k < 13; k++) begin
      push1(32'h100 + k, 32'hBFC0_0008 + 4 * k);
      step("fill");
    end
    check_eq("fill.full", {63'd0, full}, 64'd1);
    check_eq("fill.size", mq.size(), 64'd15);

    // Pair while full is dropped
    push2(32'hDEAD, 32'h1111, 32'hBEEF, 32'h2222);
    step("full.drop");
    check_eq("full.drop.size", mq.size(), 64'd15);

    // Pop 2 and push 2 together, repeatedly, walking across the wrap point
    for (int k = 0; k < 10; k++) begin
      push2(32'h200 + 2 * k, 32'hA000_0000 + 8 * k, 32'h201 + 2 * k, 32'hA000_0004 + 8 * k);
      r_en1 = 1; r_en2 = 1;
      step("wrap");
    end
    check_eq("wrap.size", mq.size(), 64'd15);

    // 5 entries then keep_ds while popping: only the head survives
    fifo_rst = 1;
    step("flush");
    for (int k = 0; k < 5; k++) begin
      push1(32'h300 + k, 32'hC000_0000 + 4 * k);
      step("five");
    end
    saved_pc = r_pc1;
    keep_ds = 1; r_en1 = 1;
    step("keepds");
    check_eq("keepds.pc1", {32'd0, r_pc1}, {32'd0, saved_pc});
    check_eq("keepds.aempty", {63'd0, almost_empty}, 64'd1);

    // keep_ds on an empty queue: next fetch keeps only slot 1
    fifo_rst = 1;
    step("flush2");
    keep_ds = 1;
    step("waitds");
    push2(32'h10, 32'hD000_0000, 32'h20, 32'hD000_0004);
    step("ds.first");
    check_eq("ds.first.inst1", {32'd0, r_inst1}, 64'h10);
    check_eq("ds.first.aempty", {63'd0, almost_empty}, 64'd1);
    push2(32'h30, 32'hD000_0008, 32'h40, 32'hD000_000C);
    step("ds.next");
    check_eq("ds.next.size", mq.size(), 64'd3);

    // delay_slot_flush overrides keep_ds
    fifo_rst = 1;
    step("flush3");
    push2(32'h50, 32'hE000_0000, 32'h51, 32'hE000_0004);
    step("three.a");
    push1(32'h52, 32'hE000_0008);
    step("three.b");
    keep_ds = 1; delay_slot_flush = 1;
    step("dsf");
    check_eq("dsf.empty", {63'd0, empty}, 64'd1);
    push2(32'h60, 32'hE100_0000, 32'h61, 32'hE100_0004);
    step("dsf.normal");
    check_eq("dsf.normal.inst2", {32'd0, r_inst2}, 64'h61);
    fifo_rst = 1;
    push2(32'h70, 32'hE200_0000, 32'h71, 32'hE200_0004);
    step("frst.push");
    check_eq("frst.push.empty", {63'd0, empty}, 64'd1);

    // Async reset between edges with 7 entries
    for (int k = 0; k < 7; k++) begin
      push1(32'h400 + k, 32'hF000_0000 + 4 * k);
      step("seven");
    end
    #2 rst = 1;
    #1;
    mq.delete();
    m_wait_ds = 1'b0;
    check_eq("arst.empty", {63'd0, empty}, 64'd1);
    check_eq("arst.inst1", {32'd0, r_inst1}, 64'd0);
    check_eq("arst.pc1", {32'd0, r_pc1}, 64'd0);
    @(negedge clk);
    rst = 0;
    push2(32'h500, 32'hF100_0000, 32'h501, 32'hF100_0004);
    step("arst.after");

    // Random legal traffic with alternating push-heavy and pop-heavy phases
    for (int c = 0; c < 3000; c++) begin
      int pb;
      pb = ((c / 200) % 2 == 0) ? 80 : 35;
      w_en1            = ($urandom_range(0, 99) < pb);
      w_en2            = w_en1 & $urandom_range(0, 1);
      r_en1            = ($urandom_range(0, 99) < (115 - pb));
      r_en2            = r_en1 & $urandom_range(0, 1);
      w_inst1          = $urandom;
      w_inst2          = $urandom;
      w_pc1            = $urandom;
      w_pc2            = $urandom;
      fifo_rst         = ($urandom_range(0, 79) == 0);
      keep_ds          = ($urandom_range(0, 39) == 0);
      delay_slot_flush = ($urandom_range(0, 149) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_inst_fifo

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
- Dual-issue instruction queue between the fetch stage and decode.
- Fetch pushes 0–2 instructions (with PCs) per cycle; decode pops 0–2 per cycle under control of the hazard unit's D_ena.
- Absorbs icache/decode rate mismatch, so d_stall does not back-pressure fetch unless the queue is full.
- Implements the branch flush, including retention of a not-yet-issued delay slot.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- DATA_W, 32, instruction and PC width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fifo_rst  in  1  synchronous flush of all entries (D_flush from hazard)
- keep_ds  in  1  flush all entries except the delay slot at head (branch issued without its delay slot)
- delay_slot_flush  in  1  exception flush; overrides keep_ds
- w_en1  in  1  push slot 1
- w_en2  in  1  push slot 2; only legal with w_en1
- w_inst1/w_inst2  in  DATA_W  instructions
- w_pc1/w_pc2  in  DATA_W  PCs
- r_en1  in  1  pop head
- r_en2  in  1  pop head+1; only legal with r_en1
- r_inst1/r_inst2  out  DATA_W  head and head+1 instructions
- r_pc1/r_pc2  out  DATA_W  head and head+1 PCs
- empty  out  1  count == 0
- almost_empty  out  1  count == 1; slot 2 output invalid
- full  out  1  count > DEPTH-2; fetch must not push

Behaviour:
- State
  - Storage array of DEPTH entries {inst, pc}; rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH); count (log2 DEPTH + 1 bits).
  - 2-state FSM: NORMAL, WAIT_DS.
- Reset
  - rd_ptr = wr_ptr = count = 0; FSM = NORMAL.
  - Outputs after reset: empty = 1, almost_empty = 0, full = 0, r_* = 0.
- Outputs
  - r_* are combinational reads at rd_ptr and rd_ptr+1 (wrapped).
  - r_* are forced to 0 when the corresponding entry is invalid.
- Latency
  - A pushed entry is visible at r_* the next cycle; no same-cycle bypass.
- NORMAL, no flush
  - pushes = w_en1 + w_en2; pops = r_en1 + r_en2, clamped to count.
  - count_next = count + pushes - pops.
  - Simultaneous push and pop at full or empty is legal: pops act on the pre-cycle contents.
  - Pushes while full are dropped.
- Flush priority: delay_slot_flush > fifo_rst > keep_ds. In every flush case, the same-cycle pushes and pops are discarded.
  - delay_slot_flush or fifo_rst: rd_ptr = wr_ptr = count = 0; FSM = NORMAL.
  - keep_ds with count >= 1: wr_ptr = rd_ptr + 1, count = 1; the head entry is retained.
  - keep_ds with count == 0: count = 0; FSM -> WAIT_DS.
- WAIT_DS (delay slot not yet fetched)
  - The first cycle with w_en1 = 1 stores slot 1 only; slot 2 is dropped.
  - FSM -> NORMAL; the new entry is visible next cycle.
  - A further keep_ds stays in WAIT_DS; delay_slot_flush or fifo_rst -> NORMAL, empty.
  - Pops are ignored while empty.
- Illegal inputs
  - w_en2 without w_en1 and r_en2 without r_en1 are covered by simulation assertions.
  - Behaviour under these inputs: slot 2 is ignored.

Optional Feature:
- Macro: INST_FIFO_PERF_EN.
- When defined, adds three outputs:
  - perf_empty_cycles: 32-bit, counts cycles with empty = 1 and FSM = NORMAL.
  - perf_full_cycles: 32-bit, counts cycles with full = 1.
  - perf_flushes: 32-bit, counts cycles with any flush input high.
- All counters saturate at 0xFFFFFFFF and reset to 0 on rst only.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef fifo_entry_t {inst, pc} (DATA_W each).
  - enum fifo_state_t {NORMAL, WAIT_DS}.
  - constant INST_FIFO_DEPTH = 16.
- Storage, pointers and FSM stay in one module; no sub-module.

Test Plan:
- Reset then idle: empty = 1, r_inst1 = 0. Push pair (0x1, pc 0xBFC00000) and (0x2, pc 0xBFC00004) -> next cycle r_pc1 = 0xBFC00000, r_pc2 = 0xBFC00004, empty = 0.
- Fill to 15 with single pushes -> full = 1. Push a pair -> ignored, count stays 15. Pop 2 with push 2 on the same cycle -> count 15. Wrap across index 15 -> 0 keeps PC order.
- 5 entries, keep_ds while r_en1 = 1 -> count 1, r_pc1 unchanged, almost_empty = 1.
- Empty, keep_ds; next cycle push pair (0x10, 0x20) -> only 0x10 stored, count 1; following push pair stores both.
- keep_ds and delay_slot_flush in the same cycle with 3 entries -> empty = 1, FSM NORMAL. fifo_rst with a simultaneous push -> empty.
- Async rst mid-stream (count 7, rst pulsed between clock edges) -> outputs clear immediately; pointers 0 after release.
